booth_mult_sequencer: RTL and testbench



---
 rtl/booth_mult_sequencer.sv | 150 +++++++++++++++
 tb/tb_booth_mult_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sequencer.sv
// Front-end for the 8x8 serial Booth multiplier: buffers operand pairs, issues them one at a
// time with a start pulse, collects the product and watches for a multiplier that never finishes.
module booth_mult_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ready,
  input  logic [15:0] mul_product,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_product_q, out_product_d;
  logic          mul_start_q, mul_start_d;
  logic [7:0]    mul_a_q, mul_a_d;
  logic [7:0]    mul_b_q, mul_b_d;
  logic          timeout_err_q, timeout_err_d;

  logic push, pop, fifo_empty, out_free, capture, expire;

  assign in_ready   = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == S_ISSUE);
  assign out_free   = !out_valid_q || out_ready;
  // The first WAIT cycle still sees the previous operation's ready flag, so it never captures.
  assign capture    = (state_q == S_WAIT) && (wcnt_q != '0) && mul_ready;
  assign expire     = (state_q == S_WAIT) && !capture && (wcnt_q == LAST_WAIT);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && out_free) begin
          state_d     = S_ISSUE;
          mul_start_d = 1'b1;
          mul_a_d     = mem_q[rd_ptr_q][15:8];
          mul_b_d     = mem_q[rd_ptr_q][7:0];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + TW'(1);
        if (capture || expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    if (capture) begin
      out_valid_d   = 1'b1;
      out_product_d = mul_product;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    timeout_err_d = timeout_err_q || expire;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      wcnt_q        <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: behavioural multiplier model, product scoreboard,
// table-driven corner vectors and hand-written multi-cycle sequences.
module tb_booth_mult_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_ready = 1'b1;
  logic [15:0] mul_product = 16'hDEAD;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  booth_mult_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] expQ[$];
  logic [15:0] gotQ[$];
  int   startCount = 0;
  logic prevStart = 1'b0;
  logic prevHold = 1'b0;
  logic [15:0] prevProd = '0;

  // Multiplier model: operands taken at the edge ending the start cycle, ready high 5 edges later.
  // Ready stays high between operations, so the sequencer's first WAIT cycle sees a stale flag.
  logic hang = 1'b0;
  logic startSeen = 1'b0;
  logic [7:0] seenA = '0, seenB = '0, mA = '0, mB = '0;
  int mulCnt = 0;

  always @(negedge clk) begin
    startSeen = mul_start;
    seenA = mul_a;
    seenB = mul_b;
  end

  always @(posedge clk) begin
    if (startSeen) begin
      mA = seenA;
      mB = seenB;
      mulCnt = 5;
    end else if (mulCnt > 0) begin
      mulCnt--;
      if (mulCnt == 4) mul_ready <= 1'b0;
      if (mulCnt == 0 && !hang) begin
        mul_ready   <= 1'b1;
        mul_product <= {8'd0, mA} * {8'd0, mB};
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      prevHold  = 1'b0;
      prevStart = 1'b0;
    end else begin
      if (mul_start) begin
        startCount++;
        checkOutput("mul_start_single_cycle", int'(prevStart), 0);
      end
      prevStart = mul_start;
      if (prevHold) begin
        checkOutput("held_out_valid", int'(out_valid), 1);
        checkOutput("held_out_product", int'(out_product), int'(prevProd));
      end
      prevHold = out_valid && !out_ready;
      prevProd = out_product;
      if (in_valid && in_ready) expQ.push_back({8'd0, in_a} * {8'd0, in_b});
      if (out_valid && out_ready) begin
        gotQ.push_back(out_product);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_product: got %0d, expected none", out_product);
        end else begin
          checkOutput("scoreboard_product", int'(out_product), int'(expQ.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_accept: got in_ready 0 for 200 cycles, expected accept");
    end
  endtask

  task automatic waitDrain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got busy=%0d out_valid=%0d, expected idle", busy, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: got out_valid 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_product"}, int'(out_product), 0);
    checkOutput({tag, "_mul_start"}, int'(mul_start), 0);
    checkOutput({tag, "_mul_a"}, int'(mul_a), 0);
    checkOutput({tag, "_mul_b"}, int'(mul_b), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  task automatic checkOrder(input string tag, input int base, input vec_t vecs[$]);
    checkOutput({tag, "_count"}, gotQ.size() - base, vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      if (base + i < gotQ.size())
        checkOutput($sformatf("%s_%0d", tag, i), int'(gotQ[base+i]), int'(vecs[i].prod));
    end
  endtask

  initial begin
    vec_t corners[$];
    vec_t bpVecs[$];
    vec_t fullVecs[$];
    vec_t one[$];
    int base, lat, sc0, sc1, pushed;
    logic sawValid;

    corners.push_back('{8'd255, 8'd255, 16'd65025});
    corners.push_back('{8'd0,   8'd77,  16'd0});
    corners.push_back('{8'd1,   8'd200, 16'd200});
    corners.push_back('{8'd128, 8'd2,   16'd256});
    bpVecs.push_back('{8'd10, 8'd20, 16'd200});
    bpVecs.push_back('{8'd30, 8'd40, 16'd1200});
    bpVecs.push_back('{8'd50, 8'd60, 16'd3000});
    for (int i = 1; i <= 6; i++) fullVecs.push_back('{8'(i), 8'(i), 16'(i * i)});

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single operation");
    out_ready = 1'b1;
    sc0 = startCount;
    applyStimulus(8'd3, 8'd5);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = i;
    end
    checkOutput("single_latency", lat, 8);
    checkOutput("single_product", int'(out_product), 15);
    waitDrain();
    checkOutput("single_start_pulses", startCount - sc0, 1);

    $display("[TB] corner operands");
    base = gotQ.size();
    foreach (corners[i]) applyStimulus(corners[i].a, corners[i].b);
    waitDrain();
    checkOrder("corner", base, corners);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    base = gotQ.size();
    sc0 = startCount;
    foreach (bpVecs[i]) applyStimulus(bpVecs[i].a, bpVecs[i].b);
    waitValid();
    sc1 = startCount;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_one_start", sc1 - sc0, 1);
    checkOutput("bp_no_second_start", startCount - sc1, 0);
    checkOutput("bp_first_product", int'(out_product), 200);
    out_ready = 1'b1;
    waitDrain();
    checkOrder("bp", base, bpVecs);

    $display("[TB] FIFO full");
    out_ready = 1'b0;
    base = gotQ.size();
    applyStimulus(8'd1, 8'd1);
    waitValid();
    for (int i = 2; i <= 5; i++) applyStimulus(8'(i), 8'(i));
    @(negedge clk);
    checkOutput("full_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = 8'd6;
    in_b = 8'd6;
    repeat (5) begin
      @(negedge clk);
      checkOutput("full_stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'd6, 8'd6);
    waitDrain();
    checkOrder("full", base, fullVecs);

    $display("[TB] random traffic");
    pushed = 0;
    for (int c = 0; c < 800 && pushed < 24; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) pushed++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("rand_pushed", pushed, 24);
    checkOutput("rand_all_delivered", expQ.size(), 0);

    $display("[TB] watchdog");
    hang = 1'b1;
    applyStimulus(8'd7, 8'd9);
    lat = 0;
    sawValid = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
      if (timeout_err) lat = i;
    end
    checkOutput("timeout_latency", lat, TIMEOUT + 2);
    checkOutput("timeout_no_out_valid", int'(sawValid), 0);
    if (expQ.size() > 0) void'(expQ.pop_front());
    hang = 1'b0;
    waitDrain();
    base = gotQ.size();
    one.delete();
    one.push_back('{8'd12, 8'd13, 16'd156});
    applyStimulus(8'd12, 8'd13);
    waitDrain();
    checkOrder("after_timeout", base, one);
    checkOutput("timeout_sticky", int'(timeout_err), 1);

    $display("[TB] reset during WAIT");
    applyStimulus(8'd100, 8'd100);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (mul_start) seen = 1'b1;
      end
      checkOutput("reset_test_start_seen", int'(seen), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sc1 = startCount;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midreset_no_late_valid", int'(sawValid), 0);
    checkOutput("midreset_no_start", startCount - sc1, 0);
    base = gotQ.size();
    one.delete();
    one.push_back('{8'd2, 8'd3, 16'd6});
    applyStimulus(8'd2, 8'd3);
    waitDrain();
    checkOrder("after_reset", base, one);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
